// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and helpers for the instruction-fetch front end.
//   XLEN_DEF  - default address/instruction width
//   DEPTH_DEF - default queue depth
//   ILEN      - PC increment in bytes
//   NOP       - canonical no-op encoding (addi x0,x0,0)
//   cnt_w()   - width of an occupancy counter that can hold 0..depth
package fetch_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 4;
  localparam int ILEN      = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEPTH_DEF);
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side bus bundle.
//   en                          fetch enable
//   imem_req/imem_addr          request to instruction memory
//   imem_rdata                  read data, one cycle after the request
//   redirect_valid/redirect_pc  flush and restart fetch
//   out_valid/out_ready         decode handshake, out_instr/out_pc head entry
//   count                       queue occupancy
// master: the fetch unit; slave: memory/decode/control side.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  import fetch_pkg::*;
  localparam int CW = cnt_w(DEPTH);

  logic            en;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  modport master (
    input  en, imem_rdata, redirect_valid, redirect_pc, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count
  );
  modport slave (
    output en, imem_rdata, redirect_valid, redirect_pc, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: DEPTH-entry synchronous FIFO (DEPTH a power of two).
//   clk, rst (sync, active-low), clr (sync flush)
//   push/wdata - write at tail; pop - advance head (caller keeps it legal)
//   rdata      - head entry (undefined when empty)
//   count      - occupied entries
module sync_fifo import fetch_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;

  // Storage needs no reset: pointers/count define what is valid.
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rptr];

  // The fetch credit scheme must never let a push land on a full queue.
  always_ff @(posedge clk)
    if (rst && !clr && push && !pop)
      assert (count != FULL) else $error("sync_fifo overflow");
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC instruction fetch with a DEPTH-entry output queue.
//   clk, rst   - clock, synchronous active-low reset
//   bus        - fetch_queue_if.master (imem request/response, redirect,
//                decode handshake, occupancy)
// Optional macro FETCH_QUEUE_BYPASS_EN: a response arriving while the queue is
// empty is presented to decode combinationally in the same cycle.
module fetch_queue import fetch_pkg::*; #(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc, req_pc;
  logic              inflight;
  logic              resp_vld, push, pop, has_head;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   head_pc, head_instr, sel_pc, sel_instr;
  logic [CW-1:0]     cnt;
  logic [CW:0]       credit;

  // Occupancy plus the outstanding response; this cycle's pop is not credited.
  assign credit       = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign bus.imem_req = rst && bus.en && !bus.redirect_valid && (credit < DEPTH_W);
  assign bus.imem_addr = fetch_pc;
  assign bus.count    = cnt;

  // A redirect in the response cycle drops that response with the flush.
  assign resp_vld = inflight && !bus.redirect_valid;
  assign has_head = (cnt != '0);
  assign {head_pc, head_instr} = head;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp           = resp_vld && !has_head;
  assign push          = resp_vld && !(byp && bus.out_ready);
  assign bus.out_valid = rst && (has_head || byp);
  assign sel_pc        = byp ? req_pc         : head_pc;
  assign sel_instr     = byp ? bus.imem_rdata : head_instr;
`else
  assign push          = resp_vld;
  assign bus.out_valid = rst && has_head;
  assign sel_pc        = head_pc;
  assign sel_instr     = head_instr;
`endif

  // Only queued entries are popped; a bypassed word never enters the FIFO.
  assign pop           = rst && has_head && bus.out_ready;
  assign bus.out_pc    = bus.out_valid ? sel_pc    : '0;
  assign bus.out_instr = bus.out_valid ? sel_instr : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= PC_RESET;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= bus.imem_req;
      if (bus.imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(ILEN);
        req_pc   <= fetch_pc;
      end
    end
  end

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.redirect_valid),
    .push  (push),
    .wdata ({req_pc, bus.imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (cnt)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven check of fetch_queue (DEPTH=4, PC_RESET=0)
// plus a hand sequence on a DEPTH=8, PC_RESET=0x8000_0000 instance covering
// redirect alignment, PC wrap and queue fill.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst4, rst8;
  int   pass = 0, total = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) b4 ();
  fetch_queue_if #(.XLEN(32), .DEPTH(8)) b8 ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0000_0000)) u4 (
    .clk(clk), .rst(rst4), .bus(b4));
  fetch_queue #(.XLEN(32), .DEPTH(8), .PC_RESET(32'h8000_0000)) u8 (
    .clk(clk), .rst(rst8), .bus(b8));

  // Memory models: 1-cycle latency, data = addr ^ A5A5_0000, junk otherwise.
  always @(posedge clk) begin
    b4.imem_rdata <= b4.imem_req ? (b4.imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    b8.imem_rdata <= b8.imem_req ? (b8.imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst, en, rdy, rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [3:0]  cnt;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(input logic r, e, rd, rv, input logic [31:0] rpc,
                              input logic q, input logic [31:0] a,
                              input logic vl, input logic [31:0] pc,
                              input logic [3:0] c);
    vec_t t;
    t.rst = r; t.en = e; t.rdy = rd; t.rv = rv; t.rpc = rpc;
    t.req = q; t.addr = a; t.vld = vl; t.pc = pc; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass, total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //        rst en rdy rv rpc          req addr          vld pc            cnt
`ifdef FETCH_QUEUE_BYPASS_EN
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0000, 0,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0004, 1,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0008, 1,32'h0000_0004, 0));
    v.push_back(mk(1,1,0,0,32'h0,       1,32'h0000_000C, 1,32'h0000_0008, 0));
    v.push_back(mk(1,1,0,0,32'h0,       1,32'h0000_0010, 1,32'h0000_0008, 1));
`else
    // steady state after reset release
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0000, 0,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0004, 0,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0008, 1,32'h0000_0000, 1));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_000C, 1,32'h0000_0004, 1));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0010, 1,32'h0000_0008, 1));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0014, 1,32'h0000_000C, 1));
    // decode stalls: queue fills, requests stop at the credit limit
    v.push_back(mk(1,1,0,0,32'h0,       1,32'h0000_0018, 1,32'h0000_0010, 1));
    v.push_back(mk(1,1,0,0,32'h0,       1,32'h0000_001C, 1,32'h0000_0010, 2));
    v.push_back(mk(1,1,0,0,32'h0,       0,32'h0000_0020, 1,32'h0000_0010, 3));
    v.push_back(mk(1,1,0,0,32'h0,       0,32'h0000_0020, 1,32'h0000_0010, 4));
    // drain in order, fetch resumes at held PC
    v.push_back(mk(1,1,1,0,32'h0,       0,32'h0000_0020, 1,32'h0000_0010, 4));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0020, 1,32'h0000_0014, 3));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0024, 1,32'h0000_0018, 2));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0028, 1,32'h0000_001C, 2));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_002C, 1,32'h0000_0020, 2));
    v.push_back(mk(1,1,0,0,32'h0,       1,32'h0000_0030, 1,32'h0000_0024, 2));
    // redirect with count=3 and a response arriving
    v.push_back(mk(1,1,0,1,32'h0000_0103,0,32'h0000_0034,1,32'h0000_0024, 3));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0100, 0,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0104, 0,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0108, 1,32'h0000_0100, 1));
    // en=0 with a request in flight: it still lands
    v.push_back(mk(1,0,0,0,32'h0,       0,32'h0000_010C, 1,32'h0000_0104, 1));
    v.push_back(mk(1,0,0,0,32'h0,       0,32'h0000_010C, 1,32'h0000_0104, 2));
    v.push_back(mk(1,1,0,0,32'h0,       1,32'h0000_010C, 1,32'h0000_0104, 2));
    // reset mid-stream with count=2
    v.push_back(mk(0,1,0,0,32'h0,       0,32'h0000_0110, 0,32'h0000_0000, 2));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0000, 0,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0004, 0,32'h0000_0000, 0));
    v.push_back(mk(1,1,1,0,32'h0,       1,32'h0000_0008, 1,32'h0000_0000, 1));
`endif

    rst4 = 1'b0; rst8 = 1'b0;
    b4.en = 1'b1; b4.out_ready = 1'b1; b4.redirect_valid = 1'b0; b4.redirect_pc = '0;
    b8.en = 1'b1; b8.out_ready = 1'b1; b8.redirect_valid = 1'b0; b8.redirect_pc = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < v.size(); i++) begin
      rst4 = v[i].rst; b4.en = v[i].en; b4.out_ready = v[i].rdy;
      b4.redirect_valid = v[i].rv; b4.redirect_pc = v[i].rpc;
      #1;
      chk($sformatf("v%0d imem_req", i),  {31'd0, b4.imem_req},  {31'd0, v[i].req});
      chk($sformatf("v%0d imem_addr", i), b4.imem_addr,          v[i].addr);
      chk($sformatf("v%0d out_valid", i), {31'd0, b4.out_valid}, {31'd0, v[i].vld});
      chk($sformatf("v%0d out_pc", i),    b4.out_pc,             v[i].pc);
      chk($sformatf("v%0d out_instr", i), b4.out_instr,
          v[i].vld ? (v[i].pc ^ 32'hA5A5_0000) : 32'h0);
      chk($sformatf("v%0d count", i),     {29'd0, b4.count},     {28'd0, v[i].cnt});
      @(negedge clk);
    end

    // DEPTH=8 instance: reset vector, misaligned redirect, PC wrap, fill.
    rst8 = 1'b1; #1;
    chk("d8 reset addr",  b8.imem_addr,          32'h8000_0000);
    chk("d8 reset req",   {31'd0, b8.imem_req},  32'd1);
    chk("d8 reset count", {28'd0, b8.count},     32'd0);
    chk("d8 reset valid", {31'd0, b8.out_valid}, 32'd0);
    @(negedge clk); #1;
    chk("d8 seq addr", b8.imem_addr, 32'h8000_0004);
    @(negedge clk);
    b8.redirect_valid = 1'b1; b8.redirect_pc = 32'hFFFF_FFFE; #1;
    chk("d8 redirect req", {31'd0, b8.imem_req}, 32'd0);
    @(negedge clk);
    b8.redirect_valid = 1'b0; b8.out_ready = 1'b0; #1;
    chk("d8 aligned addr", b8.imem_addr,         32'hFFFF_FFFC);
    chk("d8 flushed count", {28'd0, b8.count},   32'd0);
    @(negedge clk); #1;
    chk("d8 wrap addr", b8.imem_addr, 32'h0000_0000);
    chk("d8 wrap req",  {31'd0, b8.imem_req}, 32'd1);
    repeat (12) @(negedge clk);
    #1;
    chk("d8 full count", {28'd0, b8.count},     32'd8);
    chk("d8 full req",   {31'd0, b8.imem_req},  32'd0);
    chk("d8 head pc",    b8.out_pc,             32'hFFFF_FFFC);
    chk("d8 head instr", b8.out_instr,          32'h5A5A_FFFC);
    chk("d8 held addr",  b8.imem_addr,          32'h0000_001C);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the five-stage pipeline. It generates sequential PCs and issues requests to a synchronous instruction memory with 1-cycle read latency. Returned words are buffered with their PCs in a DEPTH-entry queue for the decode stage. Supports branch/jump redirect with flush and squashing of in-flight requests, plus a global enable.

Parameters:
XLEN, 32, address/instruction width in bits
DEPTH, 4, queue entries; power of two, >= 2
PC_RESET, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low; state clears on a rising edge where rst==0
en  input  1  fetch enable; 0 blocks new requests only
imem_req  output  1  request valid this cycle
imem_addr  output  XLEN  request address, word aligned
imem_rdata  input  XLEN  read data, valid exactly 1 cycle after imem_req
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head
out_instr  output  XLEN  head instruction
out_pc  output  XLEN  head PC
count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst==0 at edge):
  - fetch_pc=PC_RESET, count=0, in-flight=0, queue pointers=0.
  - Outputs: imem_req=0, out_valid=0, out_instr=0, out_pc=0.
- imem_req = en && !redirect_valid && (count + inflight < DEPTH). The pop this cycle is not credited.
- imem_addr = fetch_pc. On request: fetch_pc <= fetch_pc+4, modulo 2^XLEN wrap; inflight <= 1.
- Response: the cycle after a request, if not squashed, push {imem_rdata, request pc} at the tail.
- Credit rule guarantees push never hits a full queue. An overflow is an assertion failure.
- Pop: on out_valid && out_ready the head advances. out_valid = (count != 0).
- out_instr/out_pc are the head entry. They read 0 when empty.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Redirect (highest priority after reset):
  - Same edge: count <= 0, pointers reset.
  - Any response arriving next cycle is discarded.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - imem_req=0 in the redirect cycle. The first new request is issued the following cycle at the redirect PC.
  - A pop in the redirect cycle is still accepted by the consumer; the queue clears anyway.
- en=0: no new requests. An in-flight response still lands; pops continue. Resuming en restarts at the held fetch_pc.
- Steady state (en=1, out_ready=1): one instruction per cycle. First out_valid appears 2 cycles after reset release.
- Reset mid-operation overrides redirect, push and pop.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and a valid response arrives, it drives out_valid/out_instr/out_pc combinationally the same cycle.
  - If out_ready=1 it is consumed without entering the queue.
  - Otherwise it is written as the new head.
  - First out_valid is 1 cycle after reset release.
- Undefined: every response goes through the queue; minimum latency request-to-output is 2 cycles.

Decomposition:
- Shared package fetch_pkg:
  - XLEN default, ILEN=4 (PC increment).
  - NOP constant 32'h0000_0013.
  - Localparam for count width, $clog2(DEPTH+1).
- Sub-module sync_fifo (parametrised WIDTH, DEPTH): storage, pointers, count. Stores {pc, instr} as one 2*XLEN word.
- fetch_queue keeps the PC, credit, in-flight/squash logic and bypass mux.

Test Plan:
- Reset release, en=1, out_ready=1, imem returns addr^32'hA5A5_0000 → out_pc sequence 0,4,8,C…, one per cycle; count stays ≤1.
- out_ready=0 for 10 cycles → count rises to 4, imem_req drops to 0, fetch_pc holds at 0x10. Then out_ready=1 → entries 0,4,8,C drain in order, fetching resumes at 0x10.
- redirect_valid with redirect_pc=0x103 while count=3 and a request in flight → count=0 next cycle, late response dropped, imem_req=0 that cycle, next imem_addr=0x100, first out_pc=0x100.
- en=0 with one request in flight → that word is queued (count+1), no further imem_req; en=1 → next addr continues sequentially.
- rst=0 asserted mid-stream with count=2 → next edge count=0, out_valid=0, imem_addr=PC_RESET. Repeat with DEPTH=8, PC_RESET=0x8000_0000 and fetch_pc wrap from 0xFFFF_FFFC to 0.
- With FETCH_QUEUE_BYPASS_EN: empty queue, out_ready=1 → response visible as out_valid in the response cycle, count stays 0.
